// File: rtl/instr_sequencer.sv
// instr_sequencer: Run/Done instruction issuer with a host-loaded program store.
// Optional macro SEQ_LOOP_EN: wrap to PC=0 after the last instruction instead of halting.
module instr_sequencer #(
    parameter int AW      = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [15:0]   WrData,
    input  logic [AW:0]   ProgLen,
    input  logic          Start,
    input  logic          Stop,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [AW-1:0] PC,
    output logic [15:0]   InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t          state_q;
    logic [15:0]     mem_q [DEPTH];
    logic [AW:0]     len_q;
    logic            stop_q;
    logic [CW-1:0]   tmo_q;
    logic [15:0]     din_q;
    logic            run_q;
    logic            busy_q;
    logic            halted_q;
    logic            error_q;
    logic [AW-1:0]   pc_q;
    logic [15:0]     cnt_q;

    logic            wr_ok;
    logic            last_d;
    logic            stop_seen_d;
    logic [AW-1:0]   pc_inc_d;
    logic [15:0]     cnt_inc_d;
    logic [AW:0]     len_m1_d;

    // Next-state helpers for the sequencing decisions in WAIT
    always_comb begin
        wr_ok       = (state_q == S_IDLE) || (state_q == S_HALT) ||
                      (state_q == S_ERROR);
        len_m1_d    = len_q - {{AW{1'b0}}, 1'b1};
        last_d      = ({1'b0, pc_q} == len_m1_d);
        stop_seen_d = stop_q | Stop;
        pc_inc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
        cnt_inc_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Program store: host writes only while no run is in progress
    always_ff @(posedge Clock) begin
        if (WrEn && wr_ok) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            stop_q   <= 1'b0;
            tmo_q    <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            run_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (Start) begin
                        len_q   <= ProgLen;
                        pc_q    <= '0;
                        cnt_q   <= '0;
                        stop_q  <= 1'b0;
                        error_q <= 1'b0;
                        if (ProgLen == '0) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q  <= S_ISSUE;
                            halted_q <= 1'b0;
                            busy_q   <= 1'b1;
                            run_q    <= 1'b1;
                            din_q    <= mem_q[0];
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    tmo_q   <= '0;
                    if (Stop) begin
                        stop_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (Stop) begin
                        stop_q <= 1'b1;
                    end
                    if (Done) begin
                        cnt_q <= cnt_inc_d;
`ifdef SEQ_LOOP_EN
                        if (stop_seen_d) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else if (last_d) begin
                            state_q <= S_ISSUE;
                            pc_q    <= '0;
                            run_q   <= 1'b1;
                            din_q   <= mem_q[0];
                        end else begin
                            state_q <= S_ISSUE;
                            pc_q    <= pc_inc_d;
                            run_q   <= 1'b1;
                            din_q   <= mem_q[pc_inc_d];
                        end
`else
                        if (last_d || stop_seen_d) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                            pc_q    <= pc_inc_d;
                            run_q   <= 1'b1;
                            din_q   <= mem_q[pc_inc_d];
                        end
`endif
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DIN        = din_q;
    assign Run        = run_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Error      = error_q;
    assign PC         = pc_q;
    assign InstrCount = cnt_q;

endmodule
